// File: rtl/pellet_manager.sv
// Dot/energizer tilemaps, score, remaining count and fright timer for the maze.
// Optional `BONUS_LIFE_EN adds a one-shot extra_life pulse at the first 10000-point crossing.
module pellet_manager #(
  parameter int unsigned TILE_ROWS    = 24,
  parameter int unsigned TILE_COLS    = 32,
  parameter int unsigned TILE_SIZE    = 20,
  parameter int unsigned FRIGHT_TICKS = 600,
  parameter int unsigned DOT_POINTS   = 10,
  parameter int unsigned BIG_POINTS   = 50
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic [9:0]                     player_x,
  input  logic [8:0]                     player_y,
  input  logic [TILE_ROWS*TILE_COLS-1:0] tilemap_walls,
  output logic [TILE_ROWS*TILE_COLS-1:0] tilemap_dots,
  output logic [TILE_ROWS*TILE_COLS-1:0] tilemap_big_dots,
  output logic [15:0]                    score,
  output logic [9:0]                     dots_remaining,
  output logic                           frightened,
  output logic                           ready,
`ifdef BONUS_LIFE_EN
  output logic                           extra_life,
`endif
  output logic                           level_clear
);

  localparam int unsigned NumTiles = TILE_ROWS * TILE_COLS;
  localparam int unsigned IdxW     = $clog2(NumTiles);
  localparam int unsigned FrW      = $clog2(FRIGHT_TICKS + 1);
  localparam int unsigned Big0     = TILE_COLS + 1;
  localparam int unsigned Big1     = 2 * TILE_COLS - 2;
  localparam int unsigned Big2     = (TILE_ROWS - 2) * TILE_COLS + 1;
  localparam int unsigned Big3     = (TILE_ROWS - 1) * TILE_COLS - 2;

  typedef enum logic [1:0] {StInit, StPlay, StClear} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NumTiles-1:0]   dots_q, dots_d, big_q, big_d;
  logic [15:0]           score_q, score_d;
  logic [9:0]            rem_q, rem_d;
  logic [FrW-1:0]        fright_q, fright_d;

  // Tile under the sprite centre.
  logic [10:0]     px_c, col;
  logic [9:0]      py_c, row;
  logic            in_range, tick_play, eat_dot, eat_big, wall, bigpos;
  logic [IdxW-1:0] play_idx;
  logic [15:0]     pts;
  logic [16:0]     score_sum;

  assign px_c      = {1'b0, player_x} + 11'(TILE_SIZE / 2);
  assign py_c      = {1'b0, player_y} + 10'(TILE_SIZE / 2);
  assign col       = px_c / 11'(TILE_SIZE);
  assign row       = py_c / 10'(TILE_SIZE);
  assign in_range  = (col < 11'(TILE_COLS)) && (row < 10'(TILE_ROWS));
  assign play_idx  = IdxW'(row) * IdxW'(TILE_COLS) + IdxW'(col);
  assign tick_play = tick && (state_q == StPlay) && in_range;
  assign eat_dot   = tick_play && dots_q[play_idx];
  assign eat_big   = tick_play && big_q[play_idx];
  assign pts       = (eat_dot ? 16'(DOT_POINTS) : 16'd0) + (eat_big ? 16'(BIG_POINTS) : 16'd0);
  assign score_sum = {1'b0, score_q} + {1'b0, pts};

  assign wall   = tilemap_walls[idx_q];
  assign bigpos = (idx_q == IdxW'(Big0)) || (idx_q == IdxW'(Big1)) ||
                  (idx_q == IdxW'(Big2)) || (idx_q == IdxW'(Big3));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dots_d   = dots_q;
    big_d    = big_q;
    rem_d    = rem_q;
    score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    fright_d = fright_q;
    if (tick && (fright_q != '0)) fright_d = fright_q - 1'b1;
    unique case (state_q)
      StInit: begin
        dots_d[idx_q] = ~wall & ~bigpos;
        big_d[idx_q]  = ~wall & bigpos;
        if (!wall) rem_d = rem_q + 10'd1;
        if (idx_q == IdxW'(NumTiles - 1)) state_d = StPlay;
        else                              idx_d   = idx_q + 1'b1;
      end
      StPlay: begin
        if (eat_dot) begin
          dots_d[play_idx] = 1'b0;
          rem_d            = rem_q - 10'd1;
        end
        if (eat_big) begin
          big_d[play_idx] = 1'b0;
          rem_d           = rem_q - 10'd1;
          fright_d        = FrW'(FRIGHT_TICKS);
        end
        if (rem_q == '0) state_d = StClear;
      end
      StClear: begin
        fright_d = '0;
        rem_d    = '0;
        idx_d    = '0;
        state_d  = StInit;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StInit;
      idx_q    <= '0;
      dots_q   <= '0;
      big_q    <= '0;
      score_q  <= '0;
      rem_q    <= '0;
      fright_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dots_q   <= dots_d;
      big_q    <= big_d;
      score_q  <= score_d;
      rem_q    <= rem_d;
      fright_q <= fright_d;
    end
  end

`ifdef BONUS_LIFE_EN
  logic awarded_q, extra_life_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      awarded_q    <= 1'b0;
      extra_life_q <= 1'b0;
    end else begin
      extra_life_q <= 1'b0;
      if (!awarded_q && (score_q < 16'd10000) && (score_d >= 16'd10000)) begin
        awarded_q    <= 1'b1;
        extra_life_q <= 1'b1;
      end
    end
  end

  assign extra_life = extra_life_q;
`endif

  assign tilemap_dots     = dots_q;
  assign tilemap_big_dots = big_q;
  assign score            = score_q;
  assign dots_remaining   = rem_q;
  assign frightened       = (fright_q != '0);
  assign ready            = (state_q == StPlay);
  assign level_clear      = (state_q == StClear);

endmodule

// File: tb/tb_pellet_manager.sv
// Scoreboard bench for pellet_manager: a bench-side pellet model predicts every tick.
module tb_pellet_manager;
  localparam int NT = 768;

  logic          clk = 1'b0;
  logic          reset, tick;
  logic [9:0]    player_x;
  logic [8:0]    player_y;
  logic [NT-1:0] tilemap_walls, tilemap_dots, tilemap_big_dots;
  logic [15:0]   score;
  logic [9:0]    dots_remaining;
  logic          frightened, ready, level_clear;
`ifdef BONUS_LIFE_EN
  logic          extra_life;
`endif

  pellet_manager dut (
    .clk              (clk),
    .reset            (reset),
    .tick             (tick),
    .player_x         (player_x),
    .player_y         (player_y),
    .tilemap_walls    (tilemap_walls),
    .tilemap_dots     (tilemap_dots),
    .tilemap_big_dots (tilemap_big_dots),
    .score            (score),
    .dots_remaining   (dots_remaining),
    .frightened       (frightened),
    .ready            (ready),
`ifdef BONUS_LIFE_EN
    .extra_life       (extra_life),
`endif
    .level_clear      (level_clear)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int score;
    int rem;
    bit fr;
  } exp_t;
  exp_t sb[$];

  logic [NT-1:0] m_dots, m_big;
  int            m_score, m_rem, m_fright;

  function automatic void model_init();
    bit bp;
    m_rem = 0;
    for (int i = 0; i < NT; i++) begin
      bp        = (i == 33) || (i == 62) || (i == 705) || (i == 734);
      m_dots[i] = !tilemap_walls[i] && !bp;
      m_big[i]  = !tilemap_walls[i] && bp;
      if (!tilemap_walls[i]) m_rem++;
    end
  endfunction

  function automatic void model_tick(input int x, input int y);
    int c, r, i;
    c = (x + 10) / 20;
    r = (y + 10) / 20;
    if (m_fright != 0) m_fright--;
    if (c < 32 && r < 24) begin
      i = r * 32 + c;
      if (m_dots[i]) begin
        m_dots[i] = 1'b0;
        m_score   = (m_score + 10 > 65535) ? 65535 : m_score + 10;
        m_rem--;
      end
      if (m_big[i]) begin
        m_big[i] = 1'b0;
        m_score  = (m_score + 50 > 65535) ? 65535 : m_score + 50;
        m_rem--;
        m_fright = 600;
      end
    end
  endfunction

  task automatic do_tick(input int x, input int y, input string tag);
    exp_t e;
    @(negedge clk);
    player_x = 10'(x);
    player_y = 9'(y);
    tick     = 1'b1;
    model_tick(x, y);
    e.score = m_score;
    e.rem   = m_rem;
    e.fr    = (m_fright != 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    tick = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (score !== 16'(e.score)) begin
      n_fail++;
      $display("FAIL %s score: got %0d expected %0d", tag, score, e.score);
    end
    n_checks++;
    if (dots_remaining !== 10'(e.rem)) begin
      n_fail++;
      $display("FAIL %s remaining: got %0d expected %0d", tag, dots_remaining, e.rem);
    end
    n_checks++;
    if (frightened !== e.fr) begin
      n_fail++;
      $display("FAIL %s frightened: got %b expected %b", tag, frightened, e.fr);
    end
    n_checks++;
    if (tilemap_dots !== m_dots || tilemap_big_dots !== m_big) begin
      n_fail++;
      $display("FAIL %s maps: got dots/big ones %0d/%0d expected %0d/%0d", tag,
               $countones(tilemap_dots), $countones(tilemap_big_dots),
               $countones(m_dots), $countones(m_big));
    end
  endtask

  task automatic wait_ready(output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (ready) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    tick          = 1'b0;
    player_x      = '0;
    player_y      = '0;
    tilemap_walls = '0;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ready !== 1'b0 || level_clear !== 1'b0 || frightened !== 1'b0) begin
      n_fail++;
      $display("FAIL reset flags: got ready=%b clear=%b fr=%b expected 0 0 0",
               ready, level_clear, frightened);
    end
    n_checks++;
    if (score !== 16'd0 || dots_remaining !== 10'd0) begin
      n_fail++;
      $display("FAIL reset counts: got score=%0d rem=%0d expected 0 0", score, dots_remaining);
    end
    n_checks++;
    if (tilemap_dots !== '0 || tilemap_big_dots !== '0) begin
      n_fail++;
      $display("FAIL reset maps: got ones %0d/%0d expected 0/0",
               $countones(tilemap_dots), $countones(tilemap_big_dots));
    end
  endtask

  task automatic test_init();
    int cyc;
    @(negedge clk);
    reset = 1'b0;
    m_score  = 0;
    m_fright = 0;
    model_init();
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 768) begin
      n_fail++;
      $display("FAIL init latency: got %0d cycles expected 768", cyc);
    end
    n_checks++;
    if (dots_remaining !== 10'd768) begin
      n_fail++;
      $display("FAIL init remaining: got %0d expected 768", dots_remaining);
    end
    n_checks++;
    if (tilemap_big_dots[33] !== 1'b1 || tilemap_big_dots[62] !== 1'b1 ||
        tilemap_big_dots[705] !== 1'b1 || tilemap_big_dots[734] !== 1'b1) begin
      n_fail++;
      $display("FAIL init big corners: got %b%b%b%b expected 1111", tilemap_big_dots[33],
               tilemap_big_dots[62], tilemap_big_dots[705], tilemap_big_dots[734]);
    end
    n_checks++;
    if (tilemap_dots !== m_dots || tilemap_big_dots !== m_big) begin
      n_fail++;
      $display("FAIL init maps: got ones %0d/%0d expected %0d/%0d",
               $countones(tilemap_dots), $countones(tilemap_big_dots),
               $countones(m_dots), $countones(m_big));
    end
  endtask

  task automatic test_energizer();
    do_tick(20, 20, "energizer");
    for (int k = 0; k < 600; k++) do_tick(20, 20, "fright_run");
    n_checks++;
    if (frightened !== 1'b0) begin
      n_fail++;
      $display("FAIL fright_expire: got %b expected 0", frightened);
    end
  endtask

  task automatic test_dot_once();
    do_tick(40, 20, "dot_first");
    n_checks++;
    if (tilemap_dots[34] !== 1'b0) begin
      n_fail++;
      $display("FAIL dot34_cleared: got %b expected 0", tilemap_dots[34]);
    end
    do_tick(40, 20, "dot_repeat");
  endtask

  task automatic test_edges();
    do_tick(700, 20, "x_far");
    do_tick(20, 500, "y_far");
    do_tick(630, 20, "col32");
    do_tick(619, 20, "col31");
    do_tick(20, 470, "row24");
    do_tick(20, 469, "row23");
  endtask

  task automatic test_saturate();
    @(negedge clk);
    force dut.score_q = 16'd65530;
    @(negedge clk);
    release dut.score_q;
    m_score = 65530;
    do_tick(60, 20, "sat_dot");
    do_tick(80, 20, "sat_hold");
  endtask

  task automatic test_level_clear();
    int cyc, low, pulses;
    bit done;
    @(negedge clk);
    reset             = 1'b1;
    tilemap_walls     = '1;
    tilemap_walls[33] = 1'b0;
    tilemap_walls[34] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    m_score  = 0;
    m_fright = 0;
    model_init();
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 768 || dots_remaining !== 10'd2) begin
      n_fail++;
      $display("FAIL lc_init: got %0d cycles rem=%0d expected 768 cycles rem=2",
               cyc, dots_remaining);
    end
    do_tick(20, 20, "lc_big");
    repeat (3) do_tick(20, 20, "lc_idle");
    do_tick(40, 20, "lc_last");
    low    = 0;
    pulses = 0;
    done   = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(posedge clk);
      #1;
      if (level_clear) pulses++;
      if (ready) done = 1'b1;
      else       low++;
    end
    m_fright = 0;
    model_init();
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL lc_pulses: got %0d expected 1", pulses);
    end
    n_checks++;
    if (low !== 769) begin
      n_fail++;
      $display("FAIL lc_ready_low: got %0d cycles expected 769", low);
    end
    n_checks++;
    if (score !== 16'(m_score) || dots_remaining !== 10'(m_rem) || frightened !== 1'b0) begin
      n_fail++;
      $display("FAIL lc_after: got score=%0d rem=%0d fr=%b expected %0d %0d 0",
               score, dots_remaining, frightened, m_score, m_rem);
    end
    n_checks++;
    if (tilemap_dots !== m_dots || tilemap_big_dots !== m_big) begin
      n_fail++;
      $display("FAIL lc_refill: got ones %0d/%0d expected %0d/%0d",
               $countones(tilemap_dots), $countones(tilemap_big_dots),
               $countones(m_dots), $countones(m_big));
    end
  endtask

  task automatic test_reset_mid_init();
    int  cyc;
    bit  seen;
    do_tick(20, 20, "rm_big");
    do_tick(40, 20, "rm_dot");
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (level_clear) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rm_clear_seen: got 0 expected 1");
    end
    repeat (401) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (score !== 16'd0 || dots_remaining !== 10'd0 || ready !== 1'b0 ||
        frightened !== 1'b0 || level_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_outputs: got score=%0d rem=%0d rdy=%b fr=%b clr=%b expected all 0",
               score, dots_remaining, ready, frightened, level_clear);
    end
    n_checks++;
    if (tilemap_dots !== '0 || tilemap_big_dots !== '0) begin
      n_fail++;
      $display("FAIL rm_maps: got ones %0d/%0d expected 0/0",
               $countones(tilemap_dots), $countones(tilemap_big_dots));
    end
    @(negedge clk);
    reset = 1'b0;
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 768 || dots_remaining !== 10'd2 || score !== 16'd0) begin
      n_fail++;
      $display("FAIL rm_restart: got %0d cycles rem=%0d score=%0d expected 768 2 0",
               cyc, dots_remaining, score);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_energizer();
    test_dot_once();
    test_edges();
    test_saturate();
    test_level_clear();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
